// File: rtl/man_shiftr.sv
// rtl/man_shiftr.sv - mantissa right shifter with guard/round/sticky and registered copy
module man_shiftr (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [23:0] man,
  input  logic [4:0]  shamt,
  output logic [26:0] res,
  output logic [26:0] res_q,
  output logic        out_valid
);

  logic [26:0] ext;
  logic [26:0] sh;
  logic [31:0] mask;
  logic        sticky;

  assign ext = {man, 3'b000};
  assign sh  = ext >> shamt;

  // Low shamt bits set; for shamt >= 27 the low 27 bits are all ones, so every ext bit counts.
  assign mask   = (32'h1 << shamt) - 32'h1;
  assign sticky = |(ext & mask[26:0]);

  assign res = {sh[26:1], sh[0] | sticky};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= 27'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res_q <= res;
      end
    end
  end

endmodule

// File: tb/tb_man_shiftr.sv
// tb/tb_man_shiftr.sv - self-checking bench for man_shiftr
module tb_man_shiftr;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [23:0] man;
  logic [4:0]  shamt;
  logic [26:0] res;
  logic [26:0] res_q;
  logic        out_valid;

  int checks;
  int failures;

  logic [26:0] sb_q[$];
  logic [26:0] held_q;

  typedef struct {
    logic [23:0] man;
    logic [4:0]  shamt;
    logic [26:0] res;
  } vec_t;

  vec_t vecs[10];

  man_shiftr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .man       (man),
    .shamt     (shamt),
    .res       (res),
    .res_q     (res_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-by-bit reference: each ext bit either lands in sh or feeds the sticky OR.
  function automatic logic [26:0] model(input logic [23:0] m, input logic [4:0] s);
    logic [26:0] e;
    logic [26:0] r;
    logic        st;
    e  = {m, 3'b000};
    r  = '0;
    st = 1'b0;
    for (int i = 0; i < 27; i++) begin
      if (i < int'(s)) st = st | e[i];
      else             r[i - int'(s)] = e[i];
    end
    r[0] = r[0] | st;
    return r;
  endfunction

  task automatic check27(input string name, input logic [26:0] act, input logic [26:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // One cycle: drive on the falling edge, check res combinationally, check the registered path after the rising edge.
  task automatic step(input logic [23:0] m, input logic [4:0] s, input logic v, input logic [26:0] exp);
    logic [26:0] e;
    @(negedge clk);
    man      = m;
    shamt    = s;
    in_valid = v;
    #1;
    check27("res_comb", res, exp);
    if (v) sb_q.push_back(exp);
    @(posedge clk);
    #1;
    check1("out_valid", out_valid, v);
    if (v) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty actual=0 required=1");
      end else begin
        e = sb_q.pop_front();
        check27("res_q_capture", res_q, e);
        held_q = e;
      end
    end else begin
      check27("res_q_hold", res_q, held_q);
    end
  endtask

  initial begin
    logic [23:0] rm;
    logic [4:0]  rs;
    checks   = 0;
    failures = 0;
    held_q   = '0;

    vecs[0] = '{24'b110110011001100110011010, 5'd5,  27'b000001101100110011001100111};
    vecs[1] = '{24'b111101001100001110101101, 5'd4,  27'b000011110100110000111010111};
    vecs[2] = '{24'h800000, 5'd0,  27'h4000000};
    vecs[3] = '{24'h800000, 5'd26, 27'h0000001};
    vecs[4] = '{24'h800000, 5'd27, 27'h0000001};
    vecs[5] = '{24'h000000, 5'd31, 27'h0000000};
    vecs[6] = '{24'h000001, 5'd31, 27'h0000001};
    vecs[7] = '{24'hFFFFFF, 5'd0,  27'h7FFFFF8};
    vecs[8] = '{24'h000000, 5'd0,  27'h0000000};
    vecs[9] = '{24'hC00000, 5'd25, 27'h0000003};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    man      = 24'hABCDEF;
    shamt    = 5'd3;
    #2;
    check27("reset_res_q", res_q, 27'b0);
    check1("reset_out_valid", out_valid, 1'b0);

    // Clock edges during reset are ignored while res still tracks its inputs.
    @(negedge clk);
    in_valid = 1'b1;
    man      = vecs[0].man;
    shamt    = vecs[0].shamt;
    @(posedge clk);
    #1;
    check27("reset_hold_res_q", res_q, 27'b0);
    check1("reset_hold_out_valid", out_valid, 1'b0);
    check27("reset_res_tracks", res, vecs[0].res);

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(vecs[i].man, vecs[i].shamt, 1'b1, vecs[i].res);
    end
    step(24'h123456, 5'd7, 1'b0, model(24'h123456, 5'd7));
    step(24'h654321, 5'd2, 1'b0, model(24'h654321, 5'd2));

    // Mid-stream async reset clears the registered path immediately.
    step(vecs[1].man, vecs[1].shamt, 1'b1, vecs[1].res);
    @(negedge clk);
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check27("async_reset_res_q", res_q, 27'b0);
    check1("async_reset_out_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check1("reset_mid_no_capture", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    held_q   = '0;
    step(24'hFFFFFF, 5'd9, 1'b0, model(24'hFFFFFF, 5'd9));

    for (int i = 0; i < 200; i++) begin
      rm = 24'($urandom);
      rs = 5'($urandom_range(0, 31));
      step(rm, rs, 1'($urandom_range(0, 3) != 0), model(rm, rs));
    end

    check1("scoreboard_drained", sb_q.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
